// File: rtl/oht2bin_pipe.sv
// Pipelined one-hot to binary encoder: SPLIT-ary reduction tree, one register stage per level.
// Define OHT2BIN_PIPE_ERR_EN to build the multi-hot detection tree; otherwise err is tied low.
module oht2bin_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SPLIT = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_vld,
  output logic                       s_rdy,
  input  logic [WIDTH-1:0]           oht,
  output logic                       m_vld,
  input  logic                       m_rdy,
  output logic [$clog2(WIDTH)-1:0]   bin,
  output logic                       any,
  output logic                       err
);

  localparam int unsigned WIDTH_LOG = $clog2(WIDTH);
  localparam int unsigned SL        = $clog2(SPLIT);
  localparam int unsigned LEVELS    = (WIDTH_LOG + SL - 1) / SL;
  localparam int unsigned POWER     = SPLIT ** LEVELS;

  if (SPLIT < 2 || (SPLIT & (SPLIT - 1)) != 0) begin : g_bad_split
    $error("oht2bin_pipe: SPLIT must be a power of 2 and >= 2");
  end

  logic [POWER-1:0]  leaf;
  logic [LEVELS:0]   r;
  logic [LEVELS-1:0] v;

  assign leaf      = POWER'(oht);
  assign r[LEVELS] = m_rdy;
  assign s_rdy     = r[0];

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int unsigned N  = POWER / (SPLIT ** (k + 1));
    localparam int unsigned IW = SL * (k + 1);

    logic [N-1:0][IW-1:0] idx_d, idx_q;
    logic [N-1:0]         any_d, any_q;
    logic                 v_q;
    logic                 up_v;
`ifdef OHT2BIN_PIPE_ERR_EN
    logic [N-1:0]         err_d, err_q;
`endif

    if (k == 0) begin : g_leaf
      assign up_v = s_vld;
      always_comb begin
        for (int unsigned n = 0; n < N; n++) begin
          logic seen;
          seen     = 1'b0;
          any_d[n] = 1'b0;
          idx_d[n] = '0;
`ifdef OHT2BIN_PIPE_ERR_EN
          err_d[n] = 1'b0;
`endif
          for (int unsigned c = 0; c < SPLIT; c++) begin
            if (leaf[n*SPLIT+c]) begin
              any_d[n] = 1'b1;
              idx_d[n] = idx_d[n] | IW'(c);
`ifdef OHT2BIN_PIPE_ERR_EN
              if (seen) err_d[n] = 1'b1;
`endif
              seen = 1'b1;
            end
          end
        end
      end
    end else begin : g_node
      assign up_v = g_lvl[k-1].v_q;
      always_comb begin
        for (int unsigned n = 0; n < N; n++) begin
          logic seen;
          seen     = 1'b0;
          any_d[n] = 1'b0;
          idx_d[n] = '0;
`ifdef OHT2BIN_PIPE_ERR_EN
          err_d[n] = 1'b0;
`endif
          for (int unsigned c = 0; c < SPLIT; c++) begin
            // low bits OR across all children, so multi-hot yields the OR of set indices
            idx_d[n][IW-SL-1:0] = idx_d[n][IW-SL-1:0] | g_lvl[k-1].idx_q[n*SPLIT+c];
`ifdef OHT2BIN_PIPE_ERR_EN
            if (g_lvl[k-1].err_q[n*SPLIT+c]) err_d[n] = 1'b1;
`endif
            if (g_lvl[k-1].any_q[n*SPLIT+c]) begin
              any_d[n]            = 1'b1;
              idx_d[n][IW-1-:SL]  = idx_d[n][IW-1-:SL] | SL'(c);
`ifdef OHT2BIN_PIPE_ERR_EN
              if (seen) err_d[n] = 1'b1;
`endif
              seen = 1'b1;
            end
          end
        end
      end
    end

    assign v[k] = v_q;
    assign r[k] = ~v_q | r[k+1];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_q   <= 1'b0;
        idx_q <= '0;
        any_q <= '0;
`ifdef OHT2BIN_PIPE_ERR_EN
        err_q <= '0;
`endif
      end else if (r[k]) begin
        v_q   <= up_v;
        idx_q <= idx_d;
        any_q <= any_d;
`ifdef OHT2BIN_PIPE_ERR_EN
        err_q <= err_d;
`endif
      end
    end
  end

  assign m_vld = v[LEVELS-1];
  assign bin   = g_lvl[LEVELS-1].idx_q[0][WIDTH_LOG-1:0];
  assign any   = g_lvl[LEVELS-1].any_q[0];
`ifdef OHT2BIN_PIPE_ERR_EN
  assign err   = g_lvl[LEVELS-1].err_q[0];
`else
  assign err   = 1'b0;
`endif

endmodule

// File: tb/tb_oht2bin_pipe.sv
// Directed bench for oht2bin_pipe: a WIDTH=32/SPLIT=2 instance and a WIDTH=20/SPLIT=4 instance.
module tb_oht2bin_pipe;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        a_s_vld, a_s_rdy, a_m_vld, a_m_rdy, a_any, a_err;
  logic [31:0] a_oht;
  logic [4:0]  a_bin;

  logic        b_s_vld, b_s_rdy, b_m_vld, b_m_rdy, b_any, b_err;
  logic [19:0] b_oht;
  logic [4:0]  b_bin;

  int unsigned total = 0;
  int unsigned bad   = 0;

`ifdef OHT2BIN_PIPE_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  always #5 clk = ~clk;

  oht2bin_pipe #(.WIDTH(32), .SPLIT(2)) u_a (
    .clk(clk), .rst_n(rst_n), .s_vld(a_s_vld), .s_rdy(a_s_rdy), .oht(a_oht),
    .m_vld(a_m_vld), .m_rdy(a_m_rdy), .bin(a_bin), .any(a_any), .err(a_err)
  );

  oht2bin_pipe #(.WIDTH(20), .SPLIT(4)) u_b (
    .clk(clk), .rst_n(rst_n), .s_vld(b_s_vld), .s_rdy(b_s_rdy), .oht(b_oht),
    .m_vld(b_m_vld), .m_rdy(b_m_rdy), .bin(b_bin), .any(b_any), .err(b_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // accept one item on instance A, then count edges until m_vld (bounded)
  task automatic send_a(input logic [31:0] val, input string tag,
                        input logic [4:0] ebin, input logic eany, input logic eerr);
    int unsigned lat;
    a_oht   = val;
    a_s_vld = 1'b1;
    check({tag, "_srdy"}, a_s_rdy, 1);
    step();
    a_s_vld = 1'b0;
    lat = 0;
    while (!a_m_vld && lat < 20) begin
      step();
      lat++;
    end
    check({tag, "_lat"}, lat, 4);
    check({tag, "_bin"}, a_bin, ebin);
    check({tag, "_any"}, a_any, eany);
    check({tag, "_err"}, a_err, eerr);
    step();
  endtask

  initial begin
    int unsigned acc;
    rst_n   = 1'b0;
    a_s_vld = 1'b0; a_m_rdy = 1'b1; a_oht = '0;
    b_s_vld = 1'b0; b_m_rdy = 1'b1; b_oht = '0;
    step(); step();
    rst_n = 1'b1;

    check("rst_a_mvld", a_m_vld, 0);
    check("rst_a_bin",  a_bin,   0);
    check("rst_a_any",  a_any,   0);
    check("rst_a_err",  a_err,   0);
    check("rst_a_srdy", a_s_rdy, 1);
    check("rst_b_mvld", b_m_vld, 0);

    send_a(32'h0000_0100, "bit8",  5'd8,  1'b1, 1'b0);
    send_a(32'h8000_0000, "bit31", 5'd31, 1'b1, 1'b0);
    send_a(32'h0000_0000, "zero",  5'd0,  1'b0, 1'b0);
    send_a(32'h0000_0011, "multi", 5'd4,  1'b1, ERR_EXP);
    check("drain_a_mvld", a_m_vld, 0);

    // backpressure: fill with m_rdy low
    a_m_rdy = 1'b0;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      logic took;
      a_oht   = 32'h1 << acc;
      a_s_vld = 1'b1;
      took    = a_s_rdy;
      step();
      if (took) acc++;
    end
    a_s_vld = 1'b0;
    check("full_accepts", acc, 5);
    check("full_srdy",    a_s_rdy, 0);
    check("stall_bin",    a_bin,   0);
    step();
    check("stall_hold_bin",  a_bin,   0);
    check("stall_hold_mvld", a_m_vld, 1);

    a_m_rdy = 1'b1;
    #1;
    check("release_srdy", a_s_rdy, 1);
    for (int j = 0; j < 5; j++) begin
      check($sformatf("order_mvld%0d", j), a_m_vld, 1);
      check($sformatf("order_bin%0d", j),  a_bin,   j);
      step();
    end
    check("order_empty", a_m_vld, 0);

    // instance B: back-to-back sweep, 3-cycle latency
    for (int e = 0; e < 22; e++) begin
      if (e < 20) begin
        b_oht   = 20'h1 << e;
        b_s_vld = 1'b1;
        check($sformatf("sweep_srdy%0d", e), b_s_rdy, 1);
      end else begin
        b_s_vld = 1'b0;
      end
      step();
      if (e >= 2) begin
        check($sformatf("sweep_mvld%0d", e - 2), b_m_vld, 1);
        check($sformatf("sweep_bin%0d", e - 2),  b_bin,   e - 2);
        check($sformatf("sweep_any%0d", e - 2),  b_any,   1);
      end else begin
        check($sformatf("sweep_early%0d", e), b_m_vld, 0);
      end
    end
    step();
    check("sweep_empty", b_m_vld, 0);

    // reset mid-flight on B
    b_m_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b_oht   = 20'h1 << (i + 5);
      b_s_vld = 1'b1;
      step();
    end
    b_s_vld = 1'b0;
    check("pre_rst_full", b_s_rdy, 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("midrst_mvld", b_m_vld, 0);
    check("midrst_bin",  b_bin,   0);
    check("midrst_any",  b_any,   0);
    check("midrst_err",  b_err,   0);
    check("midrst_srdy", b_s_rdy, 1);
    b_m_rdy = 1'b1;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (b_m_vld) acc++;
    end
    check("midrst_no_ghost", acc, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
